// File: rtl/audio_sample_fifo_feeder.sv
`default_nettype none
// ============================================================================
// audio_sample_fifo_feeder : gain/mute-ramped stereo PCM packer feeding the
// audio sample FIFO, with a one-entry backpressure hold and drop counter.
// Optional build macro: AUDIO_FEEDER_DITHER_EN (LFSR dither before >>>7).
// Rev 1.0
// ============================================================================
module audio_sample_fifo_feeder #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int RAMP_STEP        = 4,
  parameter int DROP_COUNT_WIDTH = 8
) (
  input  logic                        audioClock_i,
  input  logic                        reset_i,
  input  logic                        sampleEnable_i,
  input  logic [SAMPLE_WIDTH-1:0]     leftSample_i,
  input  logic [SAMPLE_WIDTH-1:0]     rightSample_i,
  input  logic [7:0]                  gain_i,
  input  logic                        mute_i,
  input  logic                        fifoFull_i,
  output logic                        fifoWriteEnable_o,
  output logic [2*SAMPLE_WIDTH-1:0]   fifoWriteData_o,
  output logic [7:0]                  rampLevel_o,
  output logic [DROP_COUNT_WIDTH-1:0] overflowCount_o
);

  localparam int                          c_PROD_W   = 2*SAMPLE_WIDTH + 1;
  localparam int                          c_WORD_W   = 2*SAMPLE_WIDTH;
  localparam logic [7:0]                  c_UNITY    = 8'd128;
  localparam logic [8:0]                  c_STEP     = 9'(RAMP_STEP);
  localparam logic [DROP_COUNT_WIDTH-1:0] c_DROP_MAX = '1;

  typedef enum logic [1:0] {
    ST_STEADY    = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_MUTED     = 2'd3
  } ramp_state_e;

  ramp_state_e                  state_q, state_d;
  logic [7:0]                   level_q, level_d;
  logic [7:0]                   w_target;
  logic [8:0]                   w_up_sum;
  logic [7:0]                   w_level_up, w_level_dn, w_level_next;

  logic                         s1_valid_q;
  logic [SAMPLE_WIDTH-1:0]      s1_left_q, s1_right_q;
  logic [7:0]                   s1_level_q;
  logic [6:0]                   w_dither;

  logic                         s2_valid_q;
  logic [c_WORD_W-1:0]          s2_word_q;

  logic                         hold_valid_q, hold_valid_d;
  logic [c_WORD_W-1:0]          hold_word_q, hold_word_d;
  logic [DROP_COUNT_WIDTH-1:0]  ovf_q, ovf_d;
  logic                         w_drop;

  // sample * {0,level} with optional dither, arithmetic >>>7, truncated
  function automatic logic [SAMPLE_WIDTH-1:0] scale(
    input logic [SAMPLE_WIDTH-1:0] sample,
    input logic [7:0]              level,
    input logic [6:0]              dither
  );
    logic signed [c_PROD_W-1:0] s_ext;
    logic signed [c_PROD_W-1:0] l_ext;
    logic signed [c_PROD_W-1:0] d_ext;
    logic signed [c_PROD_W-1:0] acc;
    s_ext = c_PROD_W'($signed(sample));
    l_ext = c_PROD_W'({1'b0, level});
    d_ext = c_PROD_W'(dither);
    acc   = s_ext * l_ext;
    acc   = acc + d_ext;
    acc   = acc >>> 7;
    return acc[SAMPLE_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- ramp FSM
  always_comb begin
    w_target = '0;
    if (!mute_i) begin
      w_target = (gain_i > c_UNITY) ? c_UNITY : gain_i;
    end
  end

  assign w_up_sum   = {1'b0, level_q} + c_STEP;
  assign w_level_up = (w_up_sum >= {1'b0, w_target}) ? w_target : w_up_sum[7:0];
  assign w_level_dn = ({1'b0, level_q} <= ({1'b0, w_target} + c_STEP)) ?
                      w_target : (level_q - c_STEP[7:0]);

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    w_level_next = level_q;
    if (sampleEnable_i) begin
      case (state_q)
        ST_STEADY: begin
          if (w_target > level_q)      state_d = ST_RAMP_UP;
          else if (w_target < level_q) state_d = ST_RAMP_DOWN;
        end
        ST_MUTED: begin
          if (w_target != 8'd0) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP, ST_RAMP_DOWN: begin
          // Move toward the live target so a reversal never overshoots it
          if (w_target > level_q)      w_level_next = w_level_up;
          else if (w_target < level_q) w_level_next = w_level_dn;
          level_d = w_level_next;
          if (w_level_next == w_target)
            state_d = (w_target == 8'd0) ? ST_MUTED : ST_STEADY;
          else
            state_d = (w_target > level_q) ? ST_RAMP_UP : ST_RAMP_DOWN;
        end
        default: begin
          state_d = ST_MUTED;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge audioClock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RAMP_UP;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // ----------------------------------------------------------- capture stage
  always_ff @(posedge audioClock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_left_q  <= '0;
      s1_right_q <= '0;
      s1_level_q <= '0;
    end else begin
      s1_valid_q <= sampleEnable_i;
      if (sampleEnable_i) begin
        s1_left_q  <= leftSample_i;
        s1_right_q <= rightSample_i;
        s1_level_q <= level_q;
      end
    end
  end

`ifdef AUDIO_FEEDER_DITHER_EN
  logic [15:0] lfsr_q;
  logic [6:0]  s1_dither_q;

  always_ff @(posedge audioClock_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q      <= 16'hACE1;
      s1_dither_q <= '0;
    end else if (sampleEnable_i) begin
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      s1_dither_q <= lfsr_q[6:0];
    end
  end

  assign w_dither = s1_dither_q;
`else
  assign w_dither = '0;
`endif

  // -------------------------------------------------------- multiply stage
  always_ff @(posedge audioClock_i or posedge reset_i) begin
    if (reset_i) begin
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_word_q <= {scale(s1_left_q,  s1_level_q, w_dither),
                      scale(s1_right_q, s1_level_q, w_dither)};
      end
    end
  end

  // ----------------------------------------------------------- write stage
  // The held word is always older than the stage-2 word, so it goes first.
  assign fifoWriteEnable_o = !fifoFull_i && (hold_valid_q || s2_valid_q);
  assign fifoWriteData_o   = hold_valid_q ? hold_word_q : s2_word_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    w_drop       = 1'b0;
    if (hold_valid_q) begin
      if (!fifoFull_i) begin
        hold_valid_d = s2_valid_q;
        if (s2_valid_q) hold_word_d = s2_word_q;
      end else if (s2_valid_q) begin
        w_drop = 1'b1;
      end
    end else if (s2_valid_q && fifoFull_i) begin
      hold_valid_d = 1'b1;
      hold_word_d  = s2_word_q;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (w_drop && (ovf_q != c_DROP_MAX)) ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge audioClock_i or posedge reset_i) begin
    if (reset_i) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      ovf_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rampLevel_o     = level_q;
  assign overflowCount_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_fifo_feeder.sv
`default_nettype none
// ============================================================================
// tb_audio_sample_fifo_feeder : randomized bench against a behavioural model
// of ramping, scaling, write latency, backpressure hold and drop counting.
// Rev 1.0
// ============================================================================
module tb_audio_sample_fifo_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sampleEnable;
  logic [15:0] leftSample, rightSample;
  logic [7:0]  gain;
  logic        mute;
  logic        fifoFull;
  logic        fifoWriteEnable;
  logic [31:0] fifoWriteData;
  logic [7:0]  rampLevel;
  logic [7:0]  overflowCount;

  always #5 clk = ~clk;

  audio_sample_fifo_feeder #(
    .SAMPLE_WIDTH    (16),
    .RAMP_STEP       (4),
    .DROP_COUNT_WIDTH(8)
  ) dut (
    .audioClock_i     (clk),
    .reset_i          (rst),
    .sampleEnable_i   (sampleEnable),
    .leftSample_i     (leftSample),
    .rightSample_i    (rightSample),
    .gain_i           (gain),
    .mute_i           (mute),
    .fifoFull_i       (fifoFull),
    .fifoWriteEnable_o(fifoWriteEnable),
    .fifoWriteData_o  (fifoWriteData),
    .rampLevel_o      (rampLevel),
    .overflowCount_o  (overflowCount)
  );

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------ reference model
  typedef struct { logic [31:0] word; int due; } pend_t;
  pend_t       m_pipe[$];
  int          m_level;
  bit          m_moving;
  bit          m_hold_v;
  logic [31:0] m_hold_w;
  int          m_ovf;
  int          cyc = 0;

  bit          exp_we;
  logic [31:0] exp_data;
  int          exp_level;
  int          exp_ovf;

  function automatic logic [15:0] scale(input logic [15:0] s, input int lvl);
    int p;
    p = $signed(s) * lvl;
    p = p >>> 7;
    return p[15:0];
  endfunction

  task automatic model_reset;
    m_pipe.delete();
    m_level  = 0;
    m_moving = 1'b1;
    m_hold_v = 1'b0;
    m_hold_w = '0;
    m_ovf    = 0;
  endtask

  // drive this cycle's inputs, then predict this cycle's outputs
  task automatic cyc_begin(input bit se, input logic [15:0] l, input logic [15:0] r);
    bit arr;
    sampleEnable = se;
    leftSample   = l;
    rightSample  = r;
    #1;
    arr       = (m_pipe.size() > 0) && (m_pipe[0].due == cyc);
    exp_we    = !fifoFull && (m_hold_v || arr);
    exp_data  = m_hold_v ? m_hold_w : (arr ? m_pipe[0].word : 32'hxxxx_xxxx);
    exp_level = m_level;
    exp_ovf   = m_ovf;
  endtask

  task automatic cyc_end;
    bit          arr;
    logic [31:0] w;
    int          tgt;
    pend_t       p;
    arr = (m_pipe.size() > 0) && (m_pipe[0].due == cyc);
    w   = '0;
    if (arr) w = m_pipe.pop_front().word;
    if (m_hold_v) begin
      if (!fifoFull) begin
        m_hold_v = arr;
        if (arr) m_hold_w = w;
      end else if (arr) begin
        m_ovf = (m_ovf >= 255) ? 255 : m_ovf + 1;
      end
    end else if (arr && fifoFull) begin
      m_hold_v = 1'b1;
      m_hold_w = w;
    end
    if (sampleEnable) begin
      p.word = {scale(leftSample, m_level), scale(rightSample, m_level)};
      p.due  = cyc + 2;
      m_pipe.push_back(p);
      tgt = mute ? 0 : ((gain > 128) ? 128 : int'(gain));
      if (!m_moving) begin
        if (tgt != m_level) m_moving = 1'b1;
      end else begin
        if (m_level < tgt)      m_level = (m_level + 4 > tgt) ? tgt : m_level + 4;
        else if (m_level > tgt) m_level = (m_level - 4 < tgt) ? tgt : m_level - 4;
        if (m_level == tgt) m_moving = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    rst = 1'b1; sampleEnable = 1'b0; leftSample = '0; rightSample = '0;
    gain = 8'd128; mute = 1'b0; fifoFull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (fifoWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", fifoWriteEnable); end
    checks++;
    if (fifoWriteData !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", fifoWriteData); end
    checks++;
    if (rampLevel !== 8'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", rampLevel); end
    checks++;
    if (overflowCount !== 8'd0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", overflowCount); end
    checks++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp_up;
    gain = 8'd128; mute = 1'b0; fifoFull = 1'b0;
    for (int i = 0; i < 42; i++) begin
      cyc_begin(i < 40, 16'h1000, 16'hF000);
      if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
          rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
        errors++;
        $display("FAIL ramp_up cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                 fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
      end
      checks++;
      if (i < 40 && rampLevel !== 8'((4*i > 128) ? 128 : 4*i)) begin
        errors++; $display("FAIL ramp_up_level i=%0d got=%0d exp=%0d", i, rampLevel, (4*i > 128) ? 128 : 4*i);
      end
      checks++;
      if (i >= 34 && fifoWriteData !== 32'h1000F000) begin
        errors++; $display("FAIL ramp_up_unity i=%0d got=%h exp=1000f000", i, fifoWriteData);
      end
      if (i >= 34) checks++;
      cyc_end();
    end
  endtask

  task automatic test_mute;
    int want;
    fifoFull = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      mute = (pass == 0);
      for (int i = 0; i < 40; i++) begin
        cyc_begin(1'b1, 16'($urandom), 16'($urandom));
        if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
            rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
          errors++;
          $display("FAIL mute cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                   fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
        end
        checks++;
        if (pass == 0) want = (i == 0) ? 128 : ((128 - 4*(i-1) < 0) ? 0 : 128 - 4*(i-1));
        else           want = (i == 0) ? 0   : ((4*(i-1) > 128) ? 128 : 4*(i-1));
        if (rampLevel !== 8'(want)) begin
          errors++; $display("FAIL mute_level pass=%0d i=%0d got=%0d exp=%0d", pass, i, rampLevel, want);
        end
        checks++;
        cyc_end();
      end
    end
  endtask

  task automatic test_gain;
    logic [31:0] last;
    logic [31:0] want;
    mute = 1'b0; fifoFull = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      gain = (pass == 0) ? 8'd64 : 8'd200;
      want = (pass == 0) ? 32'hC0003FFF : 32'h80007FFF;
      last = '0;
      for (int i = 0; i < 27; i++) begin
        cyc_begin(i < 25, 16'h8000, 16'h7FFF);
        if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
            rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
          errors++;
          $display("FAIL gain cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                   fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
        end
        checks++;
        if (fifoWriteEnable === 1'b1) last = fifoWriteData;
        cyc_end();
      end
      if (last !== want) begin errors++; $display("FAIL gain_word pass=%0d got=%h exp=%h", pass, last, want); end
      checks++;
      if (rampLevel !== ((pass == 0) ? 8'd64 : 8'd128)) begin
        errors++; $display("FAIL gain_level pass=%0d got=%0d", pass, rampLevel);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] l0, r0;
    int          writes;
    logic [31:0] wdata;
    gain = 8'd128; mute = 1'b0;
    l0 = 16'($urandom); r0 = 16'($urandom);
    writes = 0; wdata = '0;
    for (int i = 0; i < 18; i++) begin
      fifoFull = (i >= 4 && i < 12);
      if (i == 4) cyc_begin(1'b1, l0, r0);
      else        cyc_begin(i > 4 && i < 9, 16'($urandom), 16'($urandom));
      if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
          rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
        errors++;
        $display("FAIL backpressure cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                 fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
      end
      checks++;
      if (i >= 4 && fifoWriteEnable === 1'b1) begin
        writes++; wdata = fifoWriteData;
      end
      if (i == 11) begin
        if (writes !== 0) begin errors++; $display("FAIL bp_no_write got=%0d exp=0", writes); end
        checks++;
        if (overflowCount !== 8'd4) begin errors++; $display("FAIL bp_ovf got=%0d exp=4", overflowCount); end
        checks++;
      end
      cyc_end();
    end
    if (writes !== 1) begin errors++; $display("FAIL bp_release_writes got=%0d exp=1", writes); end
    checks++;
    if (wdata !== {l0, r0}) begin errors++; $display("FAIL bp_release_data got=%h exp=%h", wdata, {l0, r0}); end
    checks++;
  endtask

  task automatic test_saturation;
    fifoFull = 1'b1;
    for (int i = 0; i < 307; i++) begin
      if (i == 303) fifoFull = 1'b0;
      cyc_begin(i < 300, 16'($urandom), 16'($urandom));
      if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
          rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
        errors++;
        $display("FAIL saturation cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                 fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
      end
      checks++;
      if (i == 303 && overflowCount !== 8'hFF) begin
        errors++; $display("FAIL saturation_ovf got=%0d exp=255", overflowCount);
      end
      if (i == 303) checks++;
      cyc_end();
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 504; i++) begin
      if (i % 50 == 0) gain = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      fifoFull = (i < 500) && ($urandom_range(0, 3) == 0);
      cyc_begin((i < 500) && ($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom));
      if (fifoWriteEnable !== exp_we || (exp_we && fifoWriteData !== exp_data) ||
          rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
        errors++;
        $display("FAIL random cyc=%0d we=%b/%b data=%h/%h level=%0d/%0d ovf=%0d/%0d", cyc,
                 fifoWriteEnable, exp_we, fifoWriteData, exp_data, rampLevel, exp_level, overflowCount, exp_ovf);
      end
      checks++;
      cyc_end();
    end
  endtask

  task automatic test_reset_midop;
    gain = 8'd128; mute = 1'b0; fifoFull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc_begin(i == 0, 16'h1234, 16'h5678);
      cyc_end();
    end
    #2;
    rst = 1'b1;
    #1;
    if (fifoWriteEnable !== 1'b0 || fifoWriteData !== 32'h0 || rampLevel !== 8'd0 || overflowCount !== 8'd0) begin
      errors++;
      $display("FAIL midop_async we=%b data=%h level=%0d ovf=%0d exp all zero",
               fifoWriteEnable, fifoWriteData, rampLevel, overflowCount);
    end
    checks++;
    fifoFull = 1'b0; sampleEnable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cyc_begin(1'b0, 16'h0, 16'h0);
      if (fifoWriteEnable !== exp_we || rampLevel !== 8'(exp_level) || overflowCount !== 8'(exp_ovf)) begin
        errors++;
        $display("FAIL midop_after cyc=%0d we=%b/%b level=%0d/%0d ovf=%0d/%0d", cyc,
                 fifoWriteEnable, exp_we, rampLevel, exp_level, overflowCount, exp_ovf);
      end
      checks++;
      cyc_end();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_mute();
    test_gain();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_sample_fifo_feeder.md
Name: audio_sample_fifo_feeder

Overview:
Audio-clock-domain stage that sits directly upstream of the 32-bit sample AsyncFifo feeding HdmiEncoder's audio path. Captures stereo PCM on sampleEnable, applies gain with click-free mute ramping, and packs {left,right} into FIFO words. Handles FIFO backpressure with a one-entry hold register and counts dropped samples.

Parameters:
SAMPLE_WIDTH, 16, bits per channel; fifoWriteData is 2*SAMPLE_WIDTH.
RAMP_STEP, 4, gain-level change per sample period while ramping (1..128).
DROP_COUNT_WIDTH, 8, width of the saturating overflow counter.

Ports:
audioClock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high; clears all state
sampleEnable  in  1  one-cycle strobe, new sample pair valid
leftSample  in  SAMPLE_WIDTH  signed left PCM
rightSample  in  SAMPLE_WIDTH  signed right PCM
gain  in  8  unsigned, 128 = unity; values >128 clamp to 128
mute  in  1  level: ramp to silence while high
fifoFull  in  1  AsyncFifo full flag (write side)
fifoWriteEnable  out  1  one-cycle FIFO write strobe
fifoWriteData  out  2*SAMPLE_WIDTH  {scaledLeft, scaledRight}, left in MSBs
rampLevel  out  8  current applied gain 0..128
overflowCount  out  DROP_COUNT_WIDTH  saturating count of dropped samples

Behaviour:
- Reset values: fifoWriteEnable=0, fifoWriteData=0, rampLevel=0, overflowCount=0, hold empty, state=RAMP_UP.
- Target = mute ? 0 : min(gain,128), evaluated each cycle.
- Ramp FSM, advances only on sampleEnable cycles (level used for that sample is the pre-update value):
  STEADY: level==target; leave to RAMP_UP if target>level, RAMP_DOWN if target<level.
  RAMP_UP: level += RAMP_STEP, clamped to target; -> STEADY on reaching it.
  RAMP_DOWN: level -= RAMP_STEP, clamped to target; -> MUTED if target==0, else STEADY.
  MUTED: level 0; -> RAMP_UP when target>0.
  Direction reversal mid-ramp switches state on the same strobe without overshoot.
- Arithmetic: product = sample (signed) * {1'b0,level} (signed 9-bit), 2*SAMPLE_WIDTH+1 bits; result = product >>> 7 (arithmetic). level<=128 so no saturation; -32768*128 -> -32768 exactly.
- Pipeline: cycle N sampleEnable captures inputs; cycle N+1 multiply registered; cycle N+2 fifoWriteEnable=1 if !fifoFull, else word held.
- Hold register (one entry): held word retried every cycle; written on the first cycle fifoFull==0. fifoWriteEnable never asserted while fifoFull==1.
- New word reaching write stage while hold occupied and fifoFull still 1: new word dropped, held (older) word kept, overflowCount += 1, saturating at all-ones.
- Same-cycle hold drain and new arrival: held word written this cycle, new word enters hold, no drop.
- sampleEnable on consecutive cycles supported (1 sample/cycle throughput when not full).
- Reset mid-operation: pipeline and hold discarded, no write strobe during or on the cycle after deassertion.

Optional Feature:
AUDIO_FEEDER_DITHER_EN: when defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances once per sampleEnable) adds lfsr[6:0] (unsigned) to each product before the >>>7; same value used for both channels. When undefined, plain truncating shift; outputs bit-exact to the arithmetic above.

Test Plan:
- Reset, gain=128, mute=0, strobe 40 samples L=16'h1000,R=16'hF000 -> rampLevel 0,4,..,128 over 32 strobes; after that fifoWriteData=32'h1000F000, write strobe 2 cycles after each sampleEnable.
- At steady unity, set mute=1 -> level falls 4/sample to 0, state MUTED, writes continue with data 0; mute=0 -> ramps back to 128.
- gain=64, L=-32768, R=32767 at steady state -> fifoWriteData={16'hC000,16'h3FFF}; gain=200 behaves as 128.
- Hold fifoFull=1, send 5 samples -> first held, overflowCount=4, no write strobe; release fifoFull -> exactly one write of the first sample.
- Keep fifoFull=1 across 300 strobes (width 8) -> overflowCount saturates at 255, no wrap.
- Assert reset with held word pending -> all outputs 0 asynchronously; after release no stray write, overflowCount=0.
